// File: rtl/extension_sequencer_if.sv
// Extension-unit bus between the sequencer (master) and the bank of
// multi-cycle extension modules (slave). Per-module signals are one bit
// per module; results are packed 32 bits per module, module i at [32i+31:32i].
interface extension_sequencer_if #(
  parameter int NUM_EXT = 4
);
  logic [NUM_EXT-1:0]    start;
  logic [NUM_EXT-1:0]    ready;
  logic [31:0]           op_a;
  logic [31:0]           op_b;
  logic [NUM_EXT-1:0]    done;
  logic [NUM_EXT*32-1:0] result;
  logic [NUM_EXT-1:0]    abort;

  modport master (
    output start, op_a, op_b, abort,
    input  ready, done, result
  );

  modport slave (
    input  start, op_a, op_b, abort,
    output ready, done, result
  );
endinterface

// File: rtl/extension_sequencer.sv
// Sequences custom-opcode instructions onto a bank of multi-cycle extension
// modules: latch the operation, start/ready handshake with the selected
// module, stall decode until done, then issue a one-cycle write-back.
// Optional feature: define EXT_TIMEOUT_EN to abort a BUSY operation that
// has not completed within TIMEOUT cycles (pulses timeout_err).
module extension_sequencer #(
  parameter int NUM_EXT = 4,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [2:0]  issue_sel,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        flush,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic        timeout_err,
  extension_sequencer_if.master ext
);

  // Reject configurations the 3-bit select or the timeout counter cannot serve.
  if (NUM_EXT < 1 || NUM_EXT > 8 || TIMEOUT < 2) begin : g_bad_param
    $error("extension_sequencer: NUM_EXT must be 1..8 and TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {IDLE, DISPATCH, BUSY, WB} state_t;

  localparam logic [3:0] NUM_EXT_L = 4'(NUM_EXT);

  state_t              state, state_n;
  logic [NUM_EXT-1:0]  issue_oh;
  logic [NUM_EXT-1:0]  sel_oh;
  logic [NUM_EXT-1:0]  start_q, start_n;
  logic [NUM_EXT-1:0]  abort_c;
  logic [31:0]         op_a_q, op_b_q;
  logic [4:0]          rd_q;
  logic [31:0]         sel_result;
  logic                sel_legal;
  logic                accept;
  logic                handshake;
  logic                done_sel;
  logic                wb_valid_q, wb_valid_n;
  logic                illegal_q, illegal_n;
  logic [4:0]          wb_rd_q;
  logic [31:0]         wb_data_q;

`ifdef EXT_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT) < 8) ? 8 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] busy_cnt;
  logic             timeout_q, timeout_n;
`endif

  // Decode the incoming select into a one-hot module mask.
  always_comb begin
    issue_oh = '0;
    for (int i = 0; i < NUM_EXT; i++) begin
      issue_oh[i] = (issue_sel == 3'(i));
    end
  end

  // Pick the latched module's result slice and its handshake bits.
  always_comb begin
    sel_result = '0;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (sel_oh[i]) sel_result = ext.result[32*i +: 32];
    end
  end

  assign sel_legal = ({1'b0, issue_sel} < NUM_EXT_L);
  assign handshake = |(ext.ready & sel_oh);
  assign done_sel  = |(ext.done & sel_oh);
  assign accept    = (state == IDLE || state == WB) && issue_valid && sel_legal && !flush;

  // Next-state and next-output decode; flush outranks every other event.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can leave a latch behind.
    state_n    = state;
    start_n    = '0;
    abort_c    = '0;
    wb_valid_n = 1'b0;
    illegal_n  = 1'b0;
`ifdef EXT_TIMEOUT_EN
    timeout_n  = 1'b0;
`endif
    case (state)
      IDLE, WB: begin
        state_n = IDLE;
        if (accept) begin
          state_n = DISPATCH;
          start_n = issue_oh;
        end else if (issue_valid && !sel_legal && !flush) begin
          illegal_n = 1'b1;
        end
      end
      DISPATCH: begin
        if (flush) begin
          abort_c = sel_oh;
          state_n = IDLE;
        end else if (handshake) begin
          state_n = BUSY;
        end else begin
          start_n = sel_oh;
        end
      end
      BUSY: begin
        if (flush) begin
          abort_c = sel_oh;
          state_n = IDLE;
        end else if (done_sel) begin
          wb_valid_n = 1'b1;
          state_n    = WB;
        end
`ifdef EXT_TIMEOUT_EN
        else if (busy_cnt == CNT_LAST) begin
          abort_c   = sel_oh;
          timeout_n = 1'b1;
          state_n   = IDLE;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Registered outputs and the latched operation.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand and write-back registers drive outputs directly, so
    // they are reset too; otherwise op_a/op_b/wb_* would read X after reset.
    if (!rst_n) begin
      start_q    <= '0;
      sel_oh     <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      start_q    <= start_n;
      wb_valid_q <= wb_valid_n;
      illegal_q  <= illegal_n;
      if (accept) begin
        sel_oh <= issue_oh;
        op_a_q <= issue_rs1;
        op_b_q <= issue_rs2;
        rd_q   <= issue_rd;
      end
      if (wb_valid_n) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= sel_result;
      end
    end
  end

`ifdef EXT_TIMEOUT_EN
  // BUSY cycle counter (zero on the first BUSY cycle) and timeout_err pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_n;
      if (state != BUSY) busy_cnt <= '0;
      else               busy_cnt <= busy_cnt + 1'b1;
    end
  end
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign stall      = (state == DISPATCH) || (state == BUSY) || (issue_valid && sel_legal);
  assign wb_valid   = wb_valid_q && !flush;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign illegal    = illegal_q;
  assign ext.start  = start_q;
  assign ext.abort  = abort_c;
  assign ext.op_a   = op_a_q;
  assign ext.op_b   = op_b_q;

endmodule

// File: tb/tb_extension_sequencer.sv
// Self-checking bench for extension_sequencer: a table of directed
// operations, hand-written flush/reset/timeout sequences, then random
// operations checked against a transaction-level expectation (selected
// module's result written to rd, illegal selects pulse illegal only).
module tb_extension_sequencer;
  localparam int NUM_EXT = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_sel = '0;
  logic [31:0] issue_rs1 = '0;
  logic [31:0] issue_rs2 = '0;
  logic [4:0]  issue_rd = '0;
  logic        flush = 1'b0;
  logic        stall, wb_valid, illegal, timeout_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  extension_sequencer_if #(.NUM_EXT(NUM_EXT)) ext_bus ();

  extension_sequencer #(.NUM_EXT(NUM_EXT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_sel(issue_sel),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .flush(flush), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal), .timeout_err(timeout_err),
    .ext(ext_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    int          rw;        // cycles ready is withheld
    int          dw;        // BUSY cycle on which done arrives (1 = first)
    logic [31:0] res;       // value on the selected module's result slice
    logic        exp_stall; // expected stall in the issue cycle
    logic        exp_ill;   // expected illegal pulse
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } op_t;

  int n_checks = 0;
  int n_errors = 0;

  logic        pending_wb = 1'b0;
  logic [4:0]  pend_rd = '0;
  logic [31:0] pend_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Compare the write-back slot of the current cycle against the expectation.
  task automatic check_wb_slot();
    if (pending_wb) begin
      check("wb_valid", 32'(wb_valid), 32'd1);
      check("wb_rd", 32'(wb_rd), 32'(pend_rd));
      check("wb_data", wb_data, pend_data);
    end else begin
      check("wb_valid_quiet", 32'(wb_valid), 32'd0);
    end
    pending_wb = 1'b0;
  endtask

  task automatic idle_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    check_wb_slot();
    check("stall_idle", 32'(stall), 32'd0);
    next();
  endtask

  // Build the expected outputs of an operation from the select rules alone.
  function automatic op_t model(input op_t op);
    op_t m = op;
    m.exp_stall = (int'(op.sel) < NUM_EXT);
    m.exp_ill   = !m.exp_stall;
    m.exp_rd    = op.rd;
    m.exp_data  = op.res;
    return m;
  endfunction

  // Issue one operation and play the extension module side. Returns at the
  // start of the write-back cycle (legal) or of the cycle after illegal.
  task automatic run_op(input op_t op);
    logic [NUM_EXT-1:0]    oh;
    logic [NUM_EXT*32-1:0] vec;
    oh = op.exp_ill ? '0 : (NUM_EXT'(1) << op.sel);
    issue_valid = 1'b1;
    issue_sel   = op.sel;
    issue_rs1   = op.rs1;
    issue_rs2   = op.rs2;
    issue_rd    = op.rd;
    @(negedge clk);
    check_wb_slot();
    check("stall_issue", 32'(stall), 32'(op.exp_stall));
    check("start_issue", 32'(ext_bus.start), 32'd0);
    next();
    issue_valid = 1'b0;
    issue_rs1   = $urandom;
    issue_rs2   = $urandom;
    if (op.exp_ill) begin
      @(negedge clk);
      check("illegal_pulse", 32'(illegal), 32'd1);
      check("stall_illegal", 32'(stall), 32'd0);
      check("start_illegal", 32'(ext_bus.start), 32'd0);
      next();
      return;
    end
    for (int w = 0; w <= op.rw; w++) begin
      ext_bus.ready = NUM_EXT'($urandom) & ~oh;
      if (w == op.rw) ext_bus.ready = ext_bus.ready | oh;
      ext_bus.done = NUM_EXT'($urandom);
      @(negedge clk);
      check("start_disp", 32'(ext_bus.start), 32'(oh));
      check("op_a", ext_bus.op_a, op.rs1);
      check("op_b", ext_bus.op_b, op.rs2);
      check("stall_disp", 32'(stall), 32'd1);
      check("illegal_disp", 32'(illegal), 32'd0);
      next();
    end
    ext_bus.ready = '0;
    for (int d = 1; d <= op.dw; d++) begin
      ext_bus.done = NUM_EXT'($urandom) & ~oh;
      vec = {$urandom, $urandom, $urandom, $urandom};
      if (d == op.dw) begin
        ext_bus.done = ext_bus.done | oh;
        vec[32*op.sel +: 32] = op.res;
      end
      ext_bus.result = vec;
      @(negedge clk);
      check("stall_busy", 32'(stall), 32'd1);
      check("start_busy", 32'(ext_bus.start), 32'd0);
      check("wb_busy", 32'(wb_valid), 32'd0);
      check("abort_busy", 32'(ext_bus.abort), 32'd0);
      check("tmo_busy", 32'(timeout_err), 32'd0);
      next();
    end
    ext_bus.done   = '0;
    ext_bus.result = {$urandom, $urandom, $urandom, $urandom};
    pending_wb = 1'b1;
    pend_rd    = op.exp_rd;
    pend_data  = op.exp_data;
  endtask

  // Issue and handshake with module sel, leaving the DUT in its first BUSY cycle.
  task automatic start_to_busy(input logic [2:0] sel);
    issue_valid = 1'b1;
    issue_sel   = sel;
    issue_rs1   = $urandom;
    issue_rs2   = $urandom;
    issue_rd    = 5'd3;
    next();
    issue_valid   = 1'b0;
    ext_bus.ready = NUM_EXT'(1) << sel;
    next();
    ext_bus.ready = '0;
  endtask

  op_t tbl[8];
  op_t op;

  initial begin
    ext_bus.ready  = '0;
    ext_bus.done   = '0;
    ext_bus.result = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_start", 32'(ext_bus.start), 32'd0);
    check("rst_abort", 32'(ext_bus.abort), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_op_a", ext_bus.op_a, 32'd0);
    check("rst_op_b", ext_bus.op_b, 32'd0);
    next();
    rst_n = 1'b1;
    next();

    // Directed table, issued back-to-back (each issue lands in the previous WB).
    //            sel   rs1           rs2           rd     rw dw res           stall ill  rd     data
    tbl[0] = '{3'd2, 32'd5,        32'd7,        5'd9,  0, 1, 32'h0000000C, 1'b1, 1'b0, 5'd9,  32'h0000000C};
    tbl[1] = '{3'd0, 32'h11111111, 32'h22222222, 5'd4,  0, 1, 32'h00000044, 1'b1, 1'b0, 5'd4,  32'h00000044};
    tbl[2] = '{3'd5, 32'h0,        32'h0,        5'd2,  0, 1, 32'h0,        1'b0, 1'b1, 5'd0,  32'h0};
    tbl[3] = '{3'd1, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd31, 4, 3, 32'hDEADBEEF, 1'b1, 1'b0, 5'd31, 32'hDEADBEEF};
    tbl[4] = '{3'd0, 32'h00000001, 32'h00000002, 5'd1,  1, 16,32'h12345678, 1'b1, 1'b0, 5'd1,  32'h12345678};
    tbl[5] = '{3'd7, 32'h0,        32'h0,        5'd6,  0, 1, 32'h0,        1'b0, 1'b1, 5'd0,  32'h0};
    tbl[6] = '{3'd3, 32'hFFFFFFFF, 32'h80000000, 5'd0,  2, 1, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd0,  32'hFFFFFFFF};
    tbl[7] = '{3'd4, 32'h0,        32'h0,        5'd8,  0, 1, 32'h0,        1'b0, 1'b1, 5'd0,  32'h0};
    for (int i = 0; i < 8; i++) run_op(tbl[i]);
    idle_cycle();

    // Flush in BUSY: abort in the flush cycle, a late done is ignored.
    start_to_busy(3'd1);
    next();
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_abort", 32'(ext_bus.abort), 32'b0010);
    check("flush_busy_stall", 32'(stall), 32'd1);
    next();
    flush = 1'b0;
    @(negedge clk);
    check("after_flush_stall", 32'(stall), 32'd0);
    check("after_flush_abort", 32'(ext_bus.abort), 32'd0);
    next();
    ext_bus.done   = 4'b0010;
    ext_bus.result = {$urandom, $urandom, $urandom, $urandom};
    next();
    ext_bus.done = '0;
    @(negedge clk);
    check("late_done_wb", 32'(wb_valid), 32'd0);
    next();

    // Flush in DISPATCH: abort while start is held, later ready is ignored.
    issue_valid = 1'b1;
    issue_sel   = 3'd3;
    next();
    issue_valid = 1'b0;
    flush       = 1'b1;
    @(negedge clk);
    check("flush_disp_abort", 32'(ext_bus.abort), 32'b1000);
    check("flush_disp_start", 32'(ext_bus.start), 32'b1000);
    next();
    flush         = 1'b0;
    ext_bus.ready = 4'b1000;
    @(negedge clk);
    check("after_fd_start", 32'(ext_bus.start), 32'd0);
    check("after_fd_stall", 32'(stall), 32'd0);
    next();
    ext_bus.ready = '0;
    ext_bus.done  = 4'b1000;
    next();
    ext_bus.done = '0;
    @(negedge clk);
    check("after_fd_wb", 32'(wb_valid), 32'd0);
    next();

    // Flush in WB with a legal issue: write-back suppressed, nothing dispatched.
    op = model('{3'd2, 32'd1, 32'd2, 5'd12, 0, 2, 32'hCAFEF00D, 1'b0, 1'b0, 5'd0, 32'd0});
    run_op(op);
    pending_wb  = 1'b0;
    issue_valid = 1'b1;
    issue_sel   = 3'd1;
    flush       = 1'b1;
    @(negedge clk);
    check("flush_wb_valid", 32'(wb_valid), 32'd0);
    next();
    issue_valid = 1'b0;
    flush       = 1'b0;
    @(negedge clk);
    check("flush_wb_start", 32'(ext_bus.start), 32'd0);
    check("flush_wb_stall", 32'(stall), 32'd0);
    next();

    // Illegal select together with flush: no illegal pulse.
    issue_valid = 1'b1;
    issue_sel   = 3'd6;
    flush       = 1'b1;
    next();
    issue_valid = 1'b0;
    flush       = 1'b0;
    @(negedge clk);
    check("flush_illegal", 32'(illegal), 32'd0);
    next();

    // Reset mid-operation: everything drops, no abort, no write-back later.
    start_to_busy(3'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_abort", 32'(ext_bus.abort), 32'd0);
    check("midrst_op_a", ext_bus.op_a, 32'd0);
    next();
    rst_n        = 1'b1;
    ext_bus.done = 4'b0001;
    next();
    ext_bus.done = '0;
    @(negedge clk);
    check("midrst_wb", 32'(wb_valid), 32'd0);
    next();

`ifdef EXT_TIMEOUT_EN
    // Done never arrives: abort in the TIMEOUT-th BUSY cycle, timeout_err after.
    start_to_busy(3'd3);
    for (int b = 1; b <= TIMEOUT; b++) begin
      @(negedge clk);
      check("tmo_abort", 32'(ext_bus.abort), (b == TIMEOUT) ? 32'b1000 : 32'd0);
      check("tmo_stall", 32'(stall), 32'd1);
      next();
    end
    @(negedge clk);
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("tmo_wb", 32'(wb_valid), 32'd0);
    check("tmo_stall_after", 32'(stall), 32'd0);
    next();
    @(negedge clk);
    check("tmo_err_pulse", 32'(timeout_err), 32'd0);
    next();
`else
    // Without the timeout, a long BUSY simply waits for done.
    op = model('{3'd3, 32'd9, 32'd8, 5'd17, 0, TIMEOUT + 4, 32'h0BADCAFE, 1'b0, 1'b0, 5'd0, 32'd0});
    run_op(op);
    idle_cycle();
`endif

    // Random operations against the transaction-level expectation.
    for (int k = 0; k < 40; k++) begin
      op.sel = 3'($urandom_range(0, 7));
      op.rs1 = $urandom;
      op.rs2 = $urandom;
      op.rd  = 5'($urandom);
      op.rw  = int'($urandom_range(0, 3));
      op.dw  = int'($urandom_range(1, 5));
      op.res = $urandom;
      run_op(model(op));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/extension_sequencer.md
# extension_sequencer

Sequences custom-opcode instructions onto a bank of multi-cycle extension modules in the shrv32 core. The decode stage supplies the module select and operands. This block latches the operation, handshakes with the selected module, and stalls the pipeline until the result returns. It then issues a single-cycle register write-back. It sits between the decode/extension-control logic and the extension units.

## Interface
- NUM_EXT, 4: number of attached extension modules, 1..8. Select values at or above this are illegal.
- TIMEOUT, 256: maximum BUSY cycles before abort. Only used with EXT_TIMEOUT_EN.
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- issue_valid  in  1  decode presents a custom-opcode instruction
- issue_sel  in  3  extension module select (funct3)
- issue_rs1, issue_rs2  in  32 each  operands
- issue_rd  in  5  destination register
- flush  in  1  pipeline flush; cancels any in-flight operation
- stall  out  1  hold PC and decode
- ext_start  out  NUM_EXT  one-hot start request
- ext_ready  in  NUM_EXT  module accepts start
- ext_op_a, ext_op_b  out  32 each  latched operands
- ext_done  in  NUM_EXT  result valid, one-cycle pulse
- ext_result  in  NUM_EXT*32  packed results; module i occupies bits [32i+31:32i]
- ext_abort  out  NUM_EXT  one-hot cancel pulse
- wb_valid  out  1  register write-back strobe
- wb_rd  out  5  write-back register
- wb_data  out  32  write-back value
- illegal  out  1  one-cycle pulse on an illegal select
- timeout_err  out  1  one-cycle pulse on timeout

## Operation
- States and transitions:
  - IDLE: a legal issue moves to DISPATCH.
  - DISPATCH: a start/ready handshake moves to BUSY.
  - BUSY: done moves to WB.
  - WB: a new legal issue moves to DISPATCH; otherwise the next state is IDLE.
- Accept rule:
  - An issue is accepted in IDLE or WB when issue_valid=1, issue_sel<NUM_EXT and flush=0.
  - On acceptance the block latches sel, rs1, rs2 and rd.
- Illegal select:
  - issue_valid with issue_sel≥NUM_EXT in IDLE or WB gives no dispatch and no stall.
  - illegal pulses on the next cycle.
- DISPATCH:
  - ext_start[sel]=1, with ext_op_a/b equal to the latched operands.
  - Held until ext_ready[sel]=1. That cycle is the handshake.
- BUSY:
  - Waits for ext_done[sel].
  - ext_done from non-selected modules is ignored.
  - The result slice for sel is captured into wb_data.
- WB: wb_valid=1 for exactly one cycle, wb_rd is the latched rd.
- stall (combinational) is 1 in any of these cases:
  - state is DISPATCH or BUSY;
  - state is IDLE or WB and a legal issue_valid is present.
- Flush:
  - Takes priority over all other events; the next state is IDLE.
  - In DISPATCH or BUSY: ext_abort[sel]=1 combinationally in the flush cycle.
  - In WB: wb_valid is forced to 0 in that cycle.
  - No illegal pulse is generated while flush=1.
- Reset:
  - The state machine enters IDLE.
  - All outputs are 0: stall, ext_start, ext_abort, wb_valid, wb_rd, wb_data, illegal, timeout_err, ext_op_a and ext_op_b.
  - Reset mid-operation drops the operation with no abort pulse. Extension modules share rst_n.

## Timing
- Minimum latency: issue at cycle 0 gives DISPATCH at cycle 1, handshake at cycle 1, BUSY at cycle 2, done at cycle 2, WB with wb_valid at cycle 3.
- ext_done coinciding with the handshake cycle is not accepted. Modules assert done no earlier than the cycle after the handshake.
- Back-to-back operations: an issue during WB writes back and re-dispatches with no idle bubble.
- ext_start, wb_* and illegal are registered. stall and ext_abort are combinational.

## Configuration
- EXT_TIMEOUT_EN defined:
  - An 8+ bit counter (width clog2(TIMEOUT)) clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT−1 without done, ext_abort[sel] pulses that cycle and the next state is IDLE.
  - timeout_err pulses on the next cycle; there is no write-back.
  - done arriving on the terminal cycle wins over the timeout.
- Undefined: BUSY waits indefinitely, timeout_err is tied to 0, and no counter is present.

## Test plan
- Module 2 result: issue sel=2, rs1=5, rs2=7, rd=9. Module 2 gives ready at cycle 1 and done with result 0x0000000C at cycle 2 → wb_valid at cycle 3 with rd=9 and data=0xC; stall is high for cycles 0–2.
- Ready backpressure: ready is withheld for 4 cycles → ext_start held 5 cycles; operands stay stable; stall stays high throughout.
- Illegal select: sel=5 with NUM_EXT=4 → illegal pulses at cycle 1; ext_start stays 0; stall stays 0.
- Flush in BUSY: flush at cycle 3 → ext_abort[sel] high in cycle 3; IDLE at cycle 4; a late done at cycle 5 produces no wb_valid.
- Timeout (EXT_TIMEOUT_EN, TIMEOUT=16): done is never asserted → ext_abort in the 16th BUSY cycle, timeout_err on the next cycle, wb_valid never asserted.
- Back-to-back: a second issue with sel=0 during WB → wb_valid for op 1 and ext_start[0] on the next cycle.
